// File: rtl/chimp_pkg.sv
// Shared constants for the chimp memory game: grid geometry, LFSR setup and
// the board loader state codes.
package chimp_pkg;

  localparam int CELLS  = 40;
  localparam int ADDR_W = 6;
  localparam int NUM_W  = 5;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Plain constants so older blocks and benches can compare against them directly.
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_PICK  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DRAW  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

endpackage

// File: rtl/chimp_lfsr16.sv
// Free-running 16-bit Galois LFSR (shift right), reloaded with the seed on reset.
module chimp_lfsr16
  import chimp_pkg::*;
(
  input  logic        clk,
  input  logic        iReset,
  output logic [15:0] oValue
);

  always_ff @(posedge clk) begin
    if (iReset)
      oValue <= LFSR_SEED;
    else if (oValue[0])
      oValue <= (oValue >> 1) ^ LFSR_TAPS;
    else
      oValue <= oValue >> 1;
  end

endmodule

// File: rtl/chimp_board_loader.sv
// Board-load sequencer: clears the cell RAM, then places 1..cnt into distinct
// random cells, handing each placement to the VGA drawer over req/ack.
module chimp_board_loader
  import chimp_pkg::*;
(
  input  logic              clk,
  input  logic              iReset,
  input  logic              iStart,
  input  logic [NUM_W-1:0]  iCount,
  input  logic              iDrawAck,
  output logic              oWrEn,
  output logic [ADDR_W-1:0] oWrAddr,
  output logic [NUM_W-1:0]  oWrData,
  output logic              oDrawReq,
  output logic [ADDR_W-1:0] oDrawAddr,
  output logic [NUM_W-1:0]  oDrawNum,
  output logic              oBusy,
  output logic              oDoneLoad
);

  logic [2:0]        state;
  logic [NUM_W-1:0]  cnt;
  logic [NUM_W-1:0]  num;
  logic [ADDR_W-1:0] clr_addr;
  logic [ADDR_W-1:0] cur_addr;
  logic [CELLS-1:0]  bitmap;
  logic [15:0]       lfsr;
  logic [ADDR_W-1:0] cand;
  logic              cand_ok;
  logic              lfsr_unused;

  chimp_lfsr16 u_lfsr (
    .clk    (clk),
    .iReset (iReset),
    .oValue (lfsr)
  );

  // Only the low bits pick a cell; out-of-grid values are simply retried.
  assign cand        = lfsr[ADDR_W-1:0];
  assign cand_ok     = (cand < ADDR_W'(CELLS)) && !bitmap[cand];
  assign lfsr_unused = ^lfsr[15:ADDR_W];

  always_ff @(posedge clk) begin
    if (iReset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      num      <= '0;
      clr_addr <= '0;
      cur_addr <= '0;
      bitmap   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (iStart) begin
            cnt      <= iCount;
            num      <= NUM_W'(1);
            clr_addr <= '0;
            bitmap   <= '0;
            state    <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          if (clr_addr == ADDR_W'(CELLS - 1))
            state <= (cnt == '0) ? S_DONE : S_PICK;
          else
            clr_addr <= clr_addr + ADDR_W'(1);
        end
        S_PICK: begin
          if (cand_ok) begin
            cur_addr <= cand;
            state    <= S_WRITE;
          end
        end
        S_WRITE: begin
          bitmap[cur_addr] <= 1'b1;
          state            <= S_DRAW;
        end
        S_DRAW: begin
          if (iDrawAck) begin
            if (num == cnt) begin
              state <= S_DONE;
            end else begin
              num   <= num + NUM_W'(1);
              state <= S_PICK;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode straight from state so they are zero outside their own states.
  always_comb begin
    oWrEn     = 1'b0;
    oWrAddr   = '0;
    oWrData   = '0;
    oDrawReq  = 1'b0;
    oDrawAddr = '0;
    oDrawNum  = '0;
    oDoneLoad = 1'b0;
    oBusy     = (state != S_IDLE);
    case (state)
      S_CLEAR: begin
        oWrEn   = 1'b1;
        oWrAddr = clr_addr;
      end
      S_WRITE: begin
        oWrEn   = 1'b1;
        oWrAddr = cur_addr;
        oWrData = num;
      end
      S_DRAW: begin
        oDrawReq  = 1'b1;
        oDrawAddr = cur_addr;
        oDrawNum  = num;
      end
      S_DONE:  oDoneLoad = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_chimp_board_loader.sv
// Randomized self-checking bench for chimp_board_loader with an acting drawer,
// a cell RAM scoreboard and a placement model driven by the LFSR rule.
module tb_chimp_board_loader;
  import chimp_pkg::*;

  logic       clk = 1'b0;
  logic       iReset, iStart, iDrawAck;
  logic [4:0] iCount;
  logic       oWrEn, oDrawReq, oBusy, oDoneLoad;
  logic [5:0] oWrAddr, oDrawAddr;
  logic [4:0] oWrData, oDrawNum;

  int total = 0;
  int bad   = 0;

  int   done_cycle, done_pulses, draw_cycles, unstable, clear_cnt, clear_bad, busy_after_done;
  int   wr_addr_q[$];
  int   wr_data_q[$];
  bit   reset_fired;
  logic [15:0] hist [0:4095];
  logic [4:0]  ram [0:39];
  logic [15:0] model_lfsr;

  always #5 clk = ~clk;

  chimp_board_loader dut (
    .clk       (clk),
    .iReset    (iReset),
    .iStart    (iStart),
    .iCount    (iCount),
    .iDrawAck  (iDrawAck),
    .oWrEn     (oWrEn),
    .oWrAddr   (oWrAddr),
    .oWrData   (oWrData),
    .oDrawReq  (oDrawReq),
    .oDrawAddr (oDrawAddr),
    .oDrawNum  (oDrawNum),
    .oBusy     (oBusy),
    .oDoneLoad (oDoneLoad)
  );

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    logic [15:0] s;
    s = v >> 1;
    if (v[0]) s = s ^ 16'hB400;
    return s;
  endfunction

  always @(posedge clk) model_lfsr <= iReset ? 16'hACE1 : lfsr_next(model_lfsr);

  // Called at a negedge; returns at the negedge inside cycle 1 of the load.
  task automatic start_load(input int count);
    iStart = 1'b1;
    iCount = 5'(count);
    @(negedge clk);
    iStart = 1'b0;
  endtask

  // Acts as drawer and RAM; inject pulses iStart in CLEAR and PICK, reset_num
  // fires iReset on the second DRAW cycle of that number.
  task automatic run_load(input int max_delay, input int budget, input int inject, input int reset_num);
    bit         prev_req = 1'b0;
    bit         injected_pick = 1'b0;
    logic [5:0] prev_addr = '0;
    logic [4:0] prev_num = '0;
    int         wait_cnt = 0, cur_delay = 0, draw_len = 0;
    done_cycle = -1; done_pulses = 0; draw_cycles = 0; unstable = 0;
    clear_cnt = 0; clear_bad = 0; busy_after_done = -1; reset_fired = 1'b0;
    wr_addr_q.delete(); wr_data_q.delete();
    for (int kk = 1; kk <= budget; kk++) begin
      hist[kk] = model_lfsr;
      if (oWrEn) begin
        if (oWrAddr < 6'd40) ram[oWrAddr] = oWrData;
        if (oWrData == 5'd0) begin
          if (oWrAddr != 6'(clear_cnt)) clear_bad++;
          clear_cnt++;
        end else begin
          wr_addr_q.push_back(int'(oWrAddr));
          wr_data_q.push_back(int'(oWrData));
        end
      end
      if (oDoneLoad) begin
        done_pulses++;
        if (done_cycle < 0) done_cycle = kk;
      end
      if (done_cycle >= 0 && kk == done_cycle + 1) busy_after_done = int'(oBusy);
      if (oDrawReq) begin
        draw_cycles++;
        if (!prev_req) begin
          wait_cnt  = 0;
          draw_len  = 0;
          cur_delay = $urandom_range(max_delay, 0);
        end else if (oDrawAddr !== prev_addr || oDrawNum !== prev_num) begin
          unstable++;
        end
        draw_len++;
        if (reset_num != 0 && int'(oDrawNum) == reset_num) begin
          iDrawAck = 1'b0;
          if (draw_len == 2) begin
            iReset      = 1'b1;
            reset_fired = 1'b1;
            return;
          end
        end else begin
          iDrawAck = (wait_cnt >= cur_delay);
          wait_cnt++;
        end
      end else begin
        iDrawAck = (max_delay > 0) ? 1'($urandom_range(1, 0)) : 1'b0;
      end
      prev_req  = oDrawReq;
      prev_addr = oDrawAddr;
      prev_num  = oDrawNum;
      iStart = 1'b0;
      if (inject != 0 && (kk == 5 || (!injected_pick && dut.state == S_PICK))) begin
        iStart = 1'b1;
        iCount = 5'd9;
        if (dut.state == S_PICK) injected_pick = 1'b1;
      end
      if (done_cycle >= 0 && kk >= done_cycle + 2) begin
        iDrawAck = 1'b0;
        iStart   = 1'b0;
        return;
      end
      @(negedge clk);
    end
    iDrawAck = 1'b0;
    iStart   = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (oBusy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%0b exp=0", oBusy); end
    total++; if (oWrEn !== 1'b0 || oDrawReq !== 1'b0 || oDoneLoad !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_strobes got=%0b%0b%0b exp=000", oWrEn, oDrawReq, oDoneLoad);
    end
    total++; if (oWrAddr !== 6'd0 || oWrData !== 5'd0 || oDrawAddr !== 6'd0 || oDrawNum !== 5'd0) begin
      bad++; $display("[TB] FAIL reset_buses got=%0d/%0d/%0d/%0d exp=0", oWrAddr, oWrData, oDrawAddr, oDrawNum);
    end
    total++; if (dut.u_lfsr.oValue !== 16'hACE1) begin
      bad++; $display("[TB] FAIL reset_seed got=%h exp=ace1", dut.u_lfsr.oValue);
    end
  endtask

  task automatic test_seed();
    int exp_addr = -1;
    iReset = 1'b1;
    @(negedge clk);
    iReset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      total++; if (dut.u_lfsr.oValue !== model_lfsr) begin
        bad++; $display("[TB] FAIL seed_seq[%0d] got=%h exp=%h", i, dut.u_lfsr.oValue, model_lfsr);
      end
      @(negedge clk);
    end
    start_load(1);
    run_load(0, 200, 0, 0);
    for (int kk = 41; kk <= 200 && exp_addr < 0; kk++)
      if (hist[kk][5:0] < 6'd40) exp_addr = int'(hist[kk][5:0]);
    total++; if (wr_addr_q.size() != 1 || wr_addr_q[0] != exp_addr) begin
      bad++; $display("[TB] FAIL seed_first_addr got=%0d (n=%0d) exp=%0d",
                      wr_addr_q.size() > 0 ? wr_addr_q[0] : -1, wr_addr_q.size(), exp_addr);
    end
  endtask

  task automatic test_count4();
    bit used [0:63];
    int kk = 41;
    int exp_addr [1:4];
    for (int i = 0; i < 64; i++) used[i] = 1'b0;
    start_load(4);
    run_load(0, 300, 0, 0);
    // Immediate ack: each accepted pick is followed by WRITE and one DRAW cycle.
    for (int n = 1; n <= 4; n++) begin
      while (kk < 300 && !(hist[kk][5:0] < 6'd40 && !used[hist[kk][5:0]])) kk++;
      exp_addr[n] = int'(hist[kk][5:0]);
      used[hist[kk][5:0]] = 1'b1;
      kk += 3;
    end
    total++; if (clear_cnt != 40 || clear_bad != 0) begin
      bad++; $display("[TB] FAIL c4_clears got=%0d badaddr=%0d exp=40/0", clear_cnt, clear_bad);
    end
    total++; if (wr_data_q.size() != 4) begin
      bad++; $display("[TB] FAIL c4_nwrites got=%0d exp=4", wr_data_q.size());
    end else begin
      for (int n = 1; n <= 4; n++) begin
        total++; if (wr_data_q[n-1] != n || wr_addr_q[n-1] != exp_addr[n]) begin
          bad++; $display("[TB] FAIL c4_write%0d got=%0d@%0d exp=%0d@%0d",
                          n, wr_data_q[n-1], wr_addr_q[n-1], n, exp_addr[n]);
        end
      end
    end
    total++; if (done_pulses != 1 || busy_after_done != 0) begin
      bad++; $display("[TB] FAIL c4_done got=%0d busy_after=%0d exp=1/0", done_pulses, busy_after_done);
    end
  endtask

  task automatic test_count0();
    start_load(0);
    run_load(0, 100, 0, 0);
    total++; if (done_cycle != 41 || done_pulses != 1) begin
      bad++; $display("[TB] FAIL c0_done_cycle got=%0d (pulses=%0d) exp=41", done_cycle, done_pulses);
    end
    total++; if (draw_cycles != 0) begin
      bad++; $display("[TB] FAIL c0_draws got=%0d exp=0", draw_cycles);
    end
  endtask

  task automatic test_count31();
    bit seen [0:63];
    int dup = 0, oob = 0, order = 0, zeros = 0;
    int hits [0:31];
    int hit_bad = 0;
    for (int i = 0; i < 64; i++) seen[i] = 1'b0;
    for (int i = 0; i < 32; i++) hits[i] = 0;
    for (int i = 0; i < 40; i++) ram[i] = 5'd17;
    start_load(31);
    run_load(5, 3000, 0, 0);
    for (int i = 0; i < wr_addr_q.size(); i++) begin
      if (wr_addr_q[i] >= 40) oob++;
      else if (seen[wr_addr_q[i]]) dup++;
      else seen[wr_addr_q[i]] = 1'b1;
      if (wr_data_q[i] != i + 1) order++;
    end
    for (int i = 0; i < 40; i++) begin
      if (ram[i] == 5'd0) zeros++;
      else hits[ram[i]]++;
    end
    for (int n = 1; n <= 31; n++) if (hits[n] != 1) hit_bad++;
    total++; if (wr_addr_q.size() != 31 || dup != 0 || oob != 0) begin
      bad++; $display("[TB] FAIL c31_addrs got=n%0d dup%0d oob%0d exp=n31 dup0 oob0", wr_addr_q.size(), dup, oob);
    end
    total++; if (order != 0) begin
      bad++; $display("[TB] FAIL c31_order got=%0d misordered exp=0", order);
    end
    total++; if (unstable != 0) begin
      bad++; $display("[TB] FAIL c31_draw_stable got=%0d changes exp=0", unstable);
    end
    total++; if (zeros != 9 || hit_bad != 0) begin
      bad++; $display("[TB] FAIL c31_ram got=zeros%0d badnums%0d exp=zeros9 badnums0", zeros, hit_bad);
    end
    total++; if (done_pulses != 1) begin
      bad++; $display("[TB] FAIL c31_done got=%0d exp=1", done_pulses);
    end
  endtask

  task automatic test_ignore_start();
    start_load(5);
    run_load(0, 600, 1, 0);
    total++; if (wr_data_q.size() != 5 || wr_data_q[0] != 1 || wr_data_q[4] != 5) begin
      bad++; $display("[TB] FAIL ign_count got=%0d writes exp=5 (1..5)", wr_data_q.size());
    end
    total++; if (done_pulses != 1 || clear_cnt != 40) begin
      bad++; $display("[TB] FAIL ign_done got=%0d clears=%0d exp=1/40", done_pulses, clear_cnt);
    end
  endtask

  task automatic test_reset_mid_draw();
    start_load(5);
    run_load(0, 600, 0, 3);
    total++; if (!reset_fired) begin
      bad++; $display("[TB] FAIL mid_reset_reached got=0 exp=1");
    end
    @(negedge clk);
    iReset = 1'b0;
    total++; if (oBusy !== 1'b0 || oWrEn !== 1'b0 || oDrawReq !== 1'b0 || oDoneLoad !== 1'b0) begin
      bad++; $display("[TB] FAIL mid_reset_outs got=busy%0b wr%0b req%0b done%0b exp=0", oBusy, oWrEn, oDrawReq, oDoneLoad);
    end
    total++; if (oDrawAddr !== 6'd0 || oDrawNum !== 5'd0 || dut.bitmap !== '0) begin
      bad++; $display("[TB] FAIL mid_reset_state got=addr%0d num%0d bitmap%h exp=0", oDrawAddr, oDrawNum, dut.bitmap);
    end
    start_load(2);
    run_load(0, 300, 0, 0);
    total++; if (clear_cnt != 40 || clear_bad != 0 || wr_data_q.size() != 2 || done_pulses != 1) begin
      bad++; $display("[TB] FAIL mid_reset_reload got=clr%0d writes%0d done%0d exp=40/2/1",
                      clear_cnt, wr_data_q.size(), done_pulses);
    end
  endtask

  initial begin
    iReset = 1'b1; iStart = 1'b0; iDrawAck = 1'b0; iCount = 5'd0;
    repeat (2) @(negedge clk);
    iReset = 1'b0;
    test_reset();
    test_seed();
    test_count4();
    test_count0();
    test_count31();
    test_ignore_start();
    test_reset_mid_draw();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
